// File: rtl/phase_clock_monitor.sv
// Two-phase clock checker: oversamples clk1/clk2 on clkIn, tracks lock and latches faults.
// Define PHASE_MON_SYNC_EN to add a 2-flop synchronizer ahead of the sample registers.
module phase_clock_monitor #(
    parameter int EXP_PERIOD  = 2,
    parameter int TOL         = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int MAX_OVERLAP = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             clk1,
    input  logic             clk2,
    input  logic             clear_fault,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] period_last,
    output logic [7:0]       fault_count
);

    typedef enum logic [1:0] {IDLE, LOCKING, LOCKED, FAULT} state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_OVERLAP = 2'd1;
    localparam logic [1:0] FC_PERIOD  = 2'd2;
    localparam logic [1:0] FC_STALL   = 2'd3;

    localparam int GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam logic [CNT_W:0] P_LO = (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : (CNT_W+1)'(0);
    localparam logic [CNT_W:0] P_HI      = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W:0] STALL_LIM = (CNT_W+1)'(2 * EXP_PERIOD + TOL);
    localparam logic [CNT_W:0] OVL_LIM   = (CNT_W+1)'(MAX_OVERLAP);

    logic p1, p2;

`ifdef PHASE_MON_SYNC_EN
    localparam int STAGES = 2;
    logic [1:0] sync1, sync2;

    always_ff @(posedge clkIn) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sync1[0], clk1};
            sync2 <= {sync2[0], clk2};
        end
    end

    assign p1 = sync1[1];
    assign p2 = sync2[1];
`else
    localparam int STAGES = 0;
    assign p1 = clk1;
    assign p2 = clk2;
`endif

    // Tracks how far real (post-reset) data has travelled down the sample path.
    logic [STAGES:0] vld_pipe;
    logic            s1, s2, s1_d, svld;

    always_ff @(posedge clkIn) begin
        if (reset) begin
            vld_pipe <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s1_d     <= 1'b0;
        end else begin
            vld_pipe[0] <= 1'b1;
            for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
            s1   <= p1;
            s2   <= p2;
            s1_d <= s1;
        end
    end

    assign svld = vld_pipe[STAGES];

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_inc, ovl, ovl_n;
    logic [CNT_W:0]    measured;
    logic [GOOD_W-1:0] good, good_n;
    logic [1:0]        code_n;
    logic              rise, good_period, stall, ovl_viol, clr;

    assign rise        = svld & s1 & ~s1_d;
    assign measured    = {1'b0, cnt} + 1'b1;
    assign cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;
    assign good_period = (measured >= P_LO) && (measured <= P_HI);
    assign stall       = ~rise && (measured >= STALL_LIM);
    assign ovl_n       = (svld && (s1 == s2)) ? ((&ovl) ? ovl : ovl + 1'b1) : '0;
    assign ovl_viol    = {1'b0, ovl_n} > OVL_LIM;

    always_comb begin
        state_n = state;
        code_n  = fault_code;
        good_n  = good;
        clr     = 1'b0;
        case (state)
            IDLE: begin
                if (ovl_viol) begin
                    state_n = FAULT;
                    code_n  = FC_OVERLAP;
                end else if (rise) begin
                    state_n = LOCKING;
                end
            end
            LOCKING: begin
                if (ovl_viol) begin
                    state_n = FAULT;
                    code_n  = FC_OVERLAP;
                end else if (stall) begin
                    state_n = FAULT;
                    code_n  = FC_STALL;
                end else if (rise) begin
                    if (!good_period) begin
                        good_n = '0;
                    end else if (good + 1'b1 == GOOD_W'(LOCK_COUNT)) begin
                        state_n = LOCKED;
                        good_n  = '0;
                    end else begin
                        good_n = good + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (ovl_viol) begin
                    state_n = FAULT;
                    code_n  = FC_OVERLAP;
                end else if (stall) begin
                    state_n = FAULT;
                    code_n  = FC_STALL;
                end else if (rise && !good_period) begin
                    state_n = FAULT;
                    code_n  = FC_PERIOD;
                end
            end
            default: begin
                // Sticky until acknowledged; detection restarts from a clean IDLE.
                if (clear_fault) begin
                    state_n = IDLE;
                    code_n  = FC_NONE;
                    good_n  = '0;
                    clr     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state       <= IDLE;
            good        <= '0;
            cnt         <= '0;
            ovl         <= '0;
            locked      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            period_last <= '0;
            fault_count <= '0;
        end else begin
            state      <= state_n;
            good       <= good_n;
            fault_code <= code_n;
            locked     <= (state_n == LOCKED);
            fault      <= (state_n == FAULT);
            if (clr) begin
                cnt <= '0;
                ovl <= '0;
            end else begin
                cnt <= rise ? '0 : cnt_inc;
                ovl <= ovl_n;
            end
            if (rise && state != IDLE)
                period_last <= measured[CNT_W] ? '1 : measured[CNT_W-1:0];
            if (state != FAULT && state_n == FAULT && fault_count != 8'hFF)
                fault_count <= fault_count + 8'd1;
        end
    end

endmodule
